// File: rtl/dma_reg_pkg.sv
// rtl/dma_reg_pkg.sv - register offsets, bit indices and decode helpers for the DMA channel register bank
package dma_reg_pkg;
  localparam int STAT_W = 8;

  localparam logic [7:0] OFF_CMD         = 8'h00;
  localparam logic [7:0] OFF_STATUS      = 8'h04;
  localparam logic [7:0] OFF_INTREN      = 8'h08;
  localparam logic [7:0] OFF_CTRL        = 8'h0C;
  localparam logic [7:0] OFF_SRCADDR     = 8'h10;
  localparam logic [7:0] OFF_DESADDR     = 8'h18;
  localparam logic [7:0] OFF_XSIZE       = 8'h20;
  localparam logic [7:0] OFF_SRCTRANSCFG = 8'h28;
  localparam logic [7:0] OFF_DESTRANSCFG = 8'h2C;
  localparam logic [7:0] OFF_XADDRINC    = 8'h30;
  localparam logic [7:0] OFF_FILLVAL     = 8'h38;
  localparam logic [7:0] OFF_LINKADDR    = 8'h78;

  localparam int CMD_ENABLE = 0;
  localparam int CMD_STOP   = 2;

  localparam int ST_DONE    = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_STOPPED = 2;

  function automatic logic off_mapped(input logic [7:0] off);
    logic v;
    case (off)
      OFF_CMD, OFF_STATUS, OFF_INTREN, OFF_CTRL, OFF_SRCADDR, OFF_DESADDR,
      OFF_XSIZE, OFF_SRCTRANSCFG, OFF_DESTRANSCFG, OFF_XADDRINC,
      OFF_FILLVAL, OFF_LINKADDR: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Registers that are frozen while the channel is enabled.
  function automatic logic off_lockable(input logic [7:0] off);
    return off_mapped(off) && (off != OFF_CMD) && (off != OFF_STATUS) && (off != OFF_INTREN);
  endfunction
endpackage

// File: rtl/dma_chn_regfile.sv
// rtl/dma_chn_regfile.sv - one DMA channel's register file with write lock, W1C status and interrupt
module dma_chn_regfile
  import dma_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [7:0]        i_off,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_upd_valid,
  input  logic [DATA_W-1:0] i_upd_srcaddr,
  input  logic [DATA_W-1:0] i_upd_desaddr,
  input  logic [DATA_W-1:0] i_upd_xsize,
  input  logic              i_done,
  input  logic [STAT_W-1:0] i_stat_set,
  output logic              o_enable,
  output logic [DATA_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_srcaddr,
  output logic [DATA_W-1:0] o_desaddr,
  output logic [DATA_W-1:0] o_xsize,
  output logic [DATA_W-1:0] o_srctranscfg,
  output logic [DATA_W-1:0] o_destranscfg,
  output logic [DATA_W-1:0] o_xaddrinc,
  output logic [DATA_W-1:0] o_fillval,
  output logic [DATA_W-1:0] o_linkaddr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_lock_err,
  output logic              o_irq
);
  logic              r_enable;
  logic [STAT_W-1:0] r_status;
  logic [STAT_W-1:0] r_intren;
  logic [DATA_W-1:0] r_ctrl, r_srcaddr, r_desaddr, r_xsize, r_srctranscfg;
  logic [DATA_W-1:0] r_destranscfg, r_xaddrinc, r_fillval, r_linkaddr;
  logic              r_irq;

  logic              w_wr_cmd;
  logic              w_stop;
  logic              w_cfg_wr;
  logic [STAT_W-1:0] w_w1c;
  logic [STAT_W-1:0] w_status_set;
  logic [DATA_W-1:0] w_rd_data;

  assign w_wr_cmd = i_wr_en && (i_off == OFF_CMD);
  assign w_stop   = w_wr_cmd && i_wr_data[CMD_STOP] && r_enable;
  assign w_cfg_wr = i_wr_en && !r_enable;
  assign w_w1c    = (i_wr_en && (i_off == OFF_STATUS)) ? i_wr_data[STAT_W-1:0] : '0;

  always_comb begin
    w_status_set             = i_stat_set;
    w_status_set[ST_DONE]    = i_stat_set[ST_DONE] | i_done;
    w_status_set[ST_STOPPED] = i_stat_set[ST_STOPPED] | w_stop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable      <= 1'b0;
      r_status      <= '0;
      r_intren      <= '0;
      r_ctrl        <= '0;
      r_srcaddr     <= '0;
      r_desaddr     <= '0;
      r_xsize       <= '0;
      r_srctranscfg <= '0;
      r_destranscfg <= '0;
      r_xaddrinc    <= '0;
      r_fillval     <= '0;
      r_linkaddr    <= '0;
      r_irq         <= 1'b0;
    end else begin
      // Hardware set is applied after the W1C mask so a same-cycle set survives.
      r_status <= (r_status & ~w_w1c) | w_status_set;
      r_irq    <= |(r_status & r_intren);
      // A software CMD write outranks chn_done so the engine can be re-armed.
      if (w_wr_cmd)
        r_enable <= w_stop ? 1'b0 : i_wr_data[CMD_ENABLE];
      else if (i_done)
        r_enable <= 1'b0;
      if (i_wr_en && (i_off == OFF_INTREN))
        r_intren <= i_wr_data[STAT_W-1:0];
      if (w_cfg_wr) begin
        case (i_off)
          OFF_CTRL:        r_ctrl        <= i_wr_data;
          OFF_SRCADDR:     r_srcaddr     <= i_wr_data;
          OFF_DESADDR:     r_desaddr     <= i_wr_data;
          OFF_XSIZE:       r_xsize       <= i_wr_data;
          OFF_SRCTRANSCFG: r_srctranscfg <= i_wr_data;
          OFF_DESTRANSCFG: r_destranscfg <= i_wr_data;
          OFF_XADDRINC:    r_xaddrinc    <= i_wr_data;
          OFF_FILLVAL:     r_fillval     <= i_wr_data;
          OFF_LINKADDR:    r_linkaddr    <= i_wr_data;
          default: ;
        endcase
      end
      if (i_upd_valid && r_enable) begin
        r_srcaddr <= i_upd_srcaddr;
        r_desaddr <= i_upd_desaddr;
        r_xsize   <= i_upd_xsize;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (i_off)
      OFF_CMD:         w_rd_data[CMD_ENABLE]   = r_enable;
      OFF_STATUS:      w_rd_data[STAT_W-1:0]   = r_status;
      OFF_INTREN:      w_rd_data[STAT_W-1:0]   = r_intren;
      OFF_CTRL:        w_rd_data = r_ctrl;
      OFF_SRCADDR:     w_rd_data = r_srcaddr;
      OFF_DESADDR:     w_rd_data = r_desaddr;
      OFF_XSIZE:       w_rd_data = r_xsize;
      OFF_SRCTRANSCFG: w_rd_data = r_srctranscfg;
      OFF_DESTRANSCFG: w_rd_data = r_destranscfg;
      OFF_XADDRINC:    w_rd_data = r_xaddrinc;
      OFF_FILLVAL:     w_rd_data = r_fillval;
      OFF_LINKADDR:    w_rd_data = r_linkaddr;
      default: ;
    endcase
  end

  assign o_rd_data     = w_rd_data;
  assign o_lock_err    = i_wr_en && r_enable && off_lockable(i_off);
  assign o_enable      = r_enable;
  assign o_irq         = r_irq;
  assign o_ctrl        = r_ctrl;
  assign o_srcaddr     = r_srcaddr;
  assign o_desaddr     = r_desaddr;
  assign o_xsize       = r_xsize;
  assign o_srctranscfg = r_srctranscfg;
  assign o_destranscfg = r_destranscfg;
  assign o_xaddrinc    = r_xaddrinc;
  assign o_fillval     = r_fillval;
  assign o_linkaddr    = r_linkaddr;
endmodule

// File: rtl/dma_chn_reg_bank_mc.sv
// rtl/dma_chn_reg_bank_mc.sv - multi-channel DMA register bank: address decode, registered read mux, error pulse
module dma_chn_reg_bank_mc
  import dma_reg_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter int CH_STRIDE_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_wr_en,
  input  logic                     cfg_rd_en,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [DATA_W-1:0]        cfg_data_in,
  output logic [DATA_W-1:0]        cfg_data_out,
  output logic                     cfg_rd_valid,
  output logic                     cfg_err,
  output logic [NUM_CH-1:0]        chn_enable,
  output logic [NUM_CH*DATA_W-1:0] chn_ctrl,
  output logic [NUM_CH*DATA_W-1:0] chn_srcaddr,
  output logic [NUM_CH*DATA_W-1:0] chn_desaddr,
  output logic [NUM_CH*DATA_W-1:0] chn_xsize,
  output logic [NUM_CH*DATA_W-1:0] chn_srctranscfg,
  output logic [NUM_CH*DATA_W-1:0] chn_destranscfg,
  output logic [NUM_CH*DATA_W-1:0] chn_xaddrinc,
  output logic [NUM_CH*DATA_W-1:0] chn_fillval,
  output logic [NUM_CH*DATA_W-1:0] chn_linkaddr,
  input  logic [NUM_CH-1:0]        chn_upd_valid,
  input  logic [NUM_CH*DATA_W-1:0] chn_upd_srcaddr,
  input  logic [NUM_CH*DATA_W-1:0] chn_upd_desaddr,
  input  logic [NUM_CH*DATA_W-1:0] chn_upd_xsize,
  input  logic [NUM_CH-1:0]        chn_done,
  input  logic [NUM_CH*8-1:0]      chn_stat_set,
  output logic [NUM_CH-1:0]        chn_irq
);
  localparam int CH_AW = ADDR_W - CH_STRIDE_LOG2;

  logic [CH_AW-1:0]  w_ch;
  logic [7:0]        w_off;
  logic              w_ch_ok;
  logic              w_mapped;
  logic              w_rd;
  logic              w_err;
  logic              w_unused_addr;
  logic [NUM_CH-1:0] w_ch_sel;
  logic [NUM_CH-1:0] w_lock_err;
  logic [DATA_W-1:0] w_rd_data_ch [NUM_CH];
  logic [DATA_W-1:0] w_rd_data;

  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  assign w_ch          = cfg_addr[ADDR_W-1:CH_STRIDE_LOG2];
  assign w_off         = 8'({cfg_addr[CH_STRIDE_LOG2-1:2], 2'b00});
  assign w_unused_addr = ^cfg_addr[1:0];
  assign w_ch_ok       = 32'(w_ch) < 32'(NUM_CH);
  assign w_mapped      = w_ch_ok && off_mapped(w_off);
  // A colliding write wins; the read half of the access is dropped.
  assign w_rd          = cfg_rd_en && !cfg_wr_en;
  assign w_err         = (cfg_wr_en && (!w_mapped || (|w_lock_err))) ||
                         (cfg_rd_en && (cfg_wr_en || !w_mapped));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ch_sel[g] = w_mapped && (w_ch == CH_AW'(g));

    dma_chn_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk           (clk),
      .reset         (reset),
      .i_wr_en       (cfg_wr_en && w_ch_sel[g]),
      .i_off         (w_off),
      .i_wr_data     (cfg_data_in),
      .i_upd_valid   (chn_upd_valid[g]),
      .i_upd_srcaddr (chn_upd_srcaddr[g*DATA_W +: DATA_W]),
      .i_upd_desaddr (chn_upd_desaddr[g*DATA_W +: DATA_W]),
      .i_upd_xsize   (chn_upd_xsize[g*DATA_W +: DATA_W]),
      .i_done        (chn_done[g]),
      .i_stat_set    (chn_stat_set[g*8 +: 8]),
      .o_enable      (chn_enable[g]),
      .o_ctrl        (chn_ctrl[g*DATA_W +: DATA_W]),
      .o_srcaddr     (chn_srcaddr[g*DATA_W +: DATA_W]),
      .o_desaddr     (chn_desaddr[g*DATA_W +: DATA_W]),
      .o_xsize       (chn_xsize[g*DATA_W +: DATA_W]),
      .o_srctranscfg (chn_srctranscfg[g*DATA_W +: DATA_W]),
      .o_destranscfg (chn_destranscfg[g*DATA_W +: DATA_W]),
      .o_xaddrinc    (chn_xaddrinc[g*DATA_W +: DATA_W]),
      .o_fillval     (chn_fillval[g*DATA_W +: DATA_W]),
      .o_linkaddr    (chn_linkaddr[g*DATA_W +: DATA_W]),
      .o_rd_data     (w_rd_data_ch[g]),
      .o_lock_err    (w_lock_err[g]),
      .o_irq         (chn_irq[g])
    );
  end

  always_comb begin
    w_rd_data = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (w_ch_sel[n]) w_rd_data = w_rd_data_ch[n];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= w_err;
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_data <= w_rd_data;
    end
  end

  assign cfg_data_out = r_rd_data;
  assign cfg_rd_valid = r_rd_valid;
  assign cfg_err      = r_err;
endmodule
